// File: rtl/bus_arbiter_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_4_pkg
// Description : Shared constants, state type and small helpers for the
//               4-requester round-robin bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_4_pkg;

    // Requester count, index width and shared bus width
    localparam int unsigned c_NUM_REQ = 4;
    localparam int unsigned c_IDX_W   = 2;
    localparam int unsigned c_BUS_W   = 32;

    // State encoding
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_BUSY = 2'b01;
    localparam logic [1:0] c_ST_TURN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_BUSY = c_ST_BUSY,
        ST_TURN = c_ST_TURN
    } arb_state_t;

    // Index following idx, wrapping 3 -> 0 through the natural 2-bit overflow
    function automatic logic [c_IDX_W-1:0] next_idx(input logic [c_IDX_W-1:0] idx);
        return idx + 2'd1;
    endfunction

    // One-hot vector with only bit idx set
    function automatic logic [c_NUM_REQ-1:0] onehot(input logic [c_IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : bus_arbiter_4_pkg
`default_nettype wire

// File: rtl/bus_arbiter_4_mux.sv
`default_nettype none
// ============================================================================
// Module      : mux4_32
// Description : 32-bit 4:1 multiplexer used for shared datapath selection.
// Ports       : i_sel          - 2-bit select
//               i_d0 .. i_d3   - 32-bit data inputs
//               o_y            - selected data
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_32 (
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_d0,
    input  logic [31:0] i_d1,
    input  logic [31:0] i_d2,
    input  logic [31:0] i_d3,
    output logic [31:0] o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            2'd3:    o_y = i_d3;
            default: o_y = i_d0;
        endcase
    end

endmodule : mux4_32
`default_nettype wire

// File: rtl/bus_arbiter_4_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Rotating-priority search. Returns the first set request bit
//               scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Ports       : req     - request vector
//               ptr     - highest-priority index for this search
//               idx     - winning index (equals ptr when no request is set)
//               any_req - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import bus_arbiter_4_pkg::*;
(
    input  logic [c_NUM_REQ-1:0] req,
    input  logic [c_IDX_W-1:0]   ptr,
    output logic [c_IDX_W-1:0]   idx,
    output logic                 any_req
);

    // Scan from lowest priority (ptr+3) up to highest (ptr) so that the
    // last assignment made is the highest-priority set bit.
    always_comb begin
        idx     = ptr;
        any_req = |req;
        for (int k = c_NUM_REQ - 1; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                idx = ptr + 2'(k);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_4
// Description : Four-requester round-robin arbiter for a shared 32-bit bus
//               with ack-based completion, request-drop abort and a BUSY
//               timeout. Grants are separated by a one-cycle TURN state.
// Parameters  : TIMEOUT   - maximum BUSY cycles before a grant is revoked
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               req       - request vector, one bit per requester
//               data_0..3 - requester payloads
//               ack       - target accepted the current transfer
//               grant     - registered one-hot grant
//               sel       - registered index of the granted requester
//               bus_valid - high while a grant is held
//               bus_data  - payload of the granted requester, 0 otherwise
//               timeout   - one-cycle pulse when a grant is revoked by timeout
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_4
    import bus_arbiter_4_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_NUM_REQ-1:0] req,
    input  logic [c_BUS_W-1:0]   data_0,
    input  logic [c_BUS_W-1:0]   data_1,
    input  logic [c_BUS_W-1:0]   data_2,
    input  logic [c_BUS_W-1:0]   data_3,
    input  logic                 ack,
    output logic [c_NUM_REQ-1:0] grant,
    output logic [c_IDX_W-1:0]   sel,
    output logic                 bus_valid,
    output logic [c_BUS_W-1:0]   bus_data,
    output logic                 timeout
);

    // Counter is wide enough to hold TIMEOUT-1
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    arb_state_t             r_state;
    logic [c_IDX_W-1:0]     r_ptr;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_NUM_REQ-1:0]   r_grant;
    logic [c_IDX_W-1:0]     r_sel;
    logic                   r_valid;

    // ------------------------------------------------------------------
    // Next-state / combinational signals
    // ------------------------------------------------------------------
    arb_state_t             w_state_nxt;
    logic [c_IDX_W-1:0]     w_ptr_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_NUM_REQ-1:0]   w_grant_nxt;
    logic [c_IDX_W-1:0]     w_sel_nxt;
    logic                   w_valid_nxt;
    logic                   w_timeout;

    logic [c_IDX_W-1:0]     w_pick;
    logic                   w_any_req;
    logic                   w_req_own;
    logic                   w_cnt_last;
    logic [c_BUS_W-1:0]     w_mux_y;

    // Rotating-priority search from the current pointer
    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (r_ptr),
        .idx     (w_pick),
        .any_req (w_any_req)
    );

    // Shared payload mux, steered by the registered select
    mux4_32 u_mux (
        .i_sel (r_sel),
        .i_d0  (data_0),
        .i_d1  (data_1),
        .i_d2  (data_2),
        .i_d3  (data_3),
        .o_y   (w_mux_y)
    );

    assign w_req_own  = req[r_sel];
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_timeout   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_any_req) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = onehot(w_pick);
                    w_sel_nxt   = w_pick;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
            end

            ST_BUSY: begin
                // Exit on ack, owner withdrawal or counter terminal. Ack has
                // precedence, so the timeout pulse only fires when the owner
                // is still requesting and the target never accepted.
                if (ack || !w_req_own || w_cnt_last) begin
                    w_state_nxt = ST_TURN;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = next_idx(r_sel);
                    w_cnt_nxt   = '0;
                    w_timeout   = !ack && w_req_own && w_cnt_last;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                end
            end

            ST_TURN: begin
                // Single dead cycle between grants; ack is ignored here
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign grant     = r_grant;
    assign sel       = r_sel;
    assign bus_valid = r_valid;
    assign bus_data  = r_valid ? w_mux_y : '0;
    assign timeout   = w_timeout;

endmodule : bus_arbiter_4
`default_nettype wire

// File: tb/tb_bus_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_4
// Description : Self-checking bench for bus_arbiter_4: vector table, directed
//               multi-cycle sequences and randomized traffic against a
//               behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_4;

    localparam int T = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        ack;
    logic [31:0] din [4];
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        bus_valid;
    logic [31:0] bus_data;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    bus_arbiter_4 #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_0    (din[0]),
        .data_1    (din[1]),
        .data_2    (din[2]),
        .data_3    (din[3]),
        .ack       (ack),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: who owns the bus, for how long, and whether the
    // mandatory dead cycle after a release is still pending.
    // ------------------------------------------------------------------
    bit m_known = 0;
    int m_owner = -1;
    bit m_cool  = 0;
    int m_ptr   = 0;
    int m_age   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        bit          v;
        logic [31:0] eg;
        logic [31:0] ed;
        bit          et;
        if (!m_known) return;
        v  = (m_owner >= 0);
        eg = v ? (32'd1 << m_owner) : 32'd0;
        ed = v ? din[m_owner] : 32'd0;
        et = v && !ack && req[m_owner] && (m_age == T - 1);
        chk("model bus_valid", 32'(bus_valid), 32'(v));
        chk("model grant", 32'(grant), eg);
        if (v) chk("model sel", 32'(sel), 32'(m_owner));
        chk("model bus_data", bus_data, ed);
        chk("model timeout", 32'(timeout), 32'(et));
    endtask

    task automatic model_step();
        bit found;
        if (rst) begin
            m_known = 1;
            m_owner = -1;
            m_cool  = 0;
            m_ptr   = 0;
            m_age   = 0;
        end else if (!m_known) begin
            // nothing known before the first reset
        end else if (m_owner >= 0) begin
            if (ack || !req[m_owner] || m_age == T - 1) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_age++;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (req != 4'b0000) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req[(m_ptr + k) % 4]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % 4;
                    m_age   = 0;
                end
            end
        end
    endtask

    // Drive inputs just after an edge, then look at the outputs mid-cycle
    task automatic settle(input bit r, input logic [3:0] q, input bit a);
        rst = r;
        req = q;
        ack = a;
        #4;
        model_compare();
    endtask

    task automatic step_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Vector table: inputs for a cycle and the registered outputs expected
    // during that same cycle.
    // ------------------------------------------------------------------
    typedef struct {
        bit         r;
        logic [3:0] q;
        bit         a;
        logic [3:0] g;
        bit         v;
        logic [1:0] s;
    } vec_t;

    vec_t tbl [22];

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        ack = 1'b0;
        din[0] = 32'h1111_0000;
        din[1] = 32'h2222_1111;
        din[2] = 32'hDEAD_BEEF;
        din[3] = 32'h4444_3333;

        // basic grant of index 2, then completion
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        // round robin with all requesting and ack always high
        tbl[6]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[13] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[15] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[16] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[17] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        // wrap-around: after index 3, req 1001 must pick index 0
        tbl[18] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[19] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[20] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[21] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};

        @(posedge clk);
        #1;
        settle(1'b1, 4'b0000, 1'b0);
        step_edge();
        settle(1'b1, 4'b0000, 1'b0);
        step_edge();

        // ---------------- table ----------------
        for (int i = 0; i < 22; i++) begin
            settle(tbl[i].r, tbl[i].q, tbl[i].a);
            chk($sformatf("tbl[%0d] grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("tbl[%0d] bus_valid", i), 32'(bus_valid), 32'(tbl[i].v));
            if (tbl[i].v) chk($sformatf("tbl[%0d] sel", i), 32'(sel), 32'(tbl[i].s));
            if (i == 2) chk("basic bus_data", bus_data, 32'hDEAD_BEEF);
            if (!tbl[i].v) chk($sformatf("tbl[%0d] bus_data zero", i), bus_data, 32'h0);
            step_edge();
        end

        // ---------------- timeout ----------------
        settle(1'b1, 4'b0000, 1'b0);
        step_edge();
        settle(1'b0, 4'b0010, 1'b0);
        step_edge();
        for (int n = 1; n <= T; n++) begin
            settle(1'b0, 4'b0010, 1'b0);
            chk($sformatf("timeout busy cycle %0d", n), 32'(timeout), 32'(n == T));
            chk($sformatf("timeout grant cycle %0d", n), 32'(grant), 32'h2);
            step_edge();
        end
        settle(1'b0, 4'b0010, 1'b0);
        chk("timeout turn grant", 32'(grant), 32'h0);
        chk("timeout turn pulse gone", 32'(timeout), 32'h0);
        step_edge();
        settle(1'b0, 4'b0010, 1'b0);
        chk("timeout idle grant", 32'(grant), 32'h0);
        step_edge();
        settle(1'b0, 4'b0010, 1'b0);
        chk("timeout regrant", 32'(grant), 32'h2);
        step_edge();
        settle(1'b0, 4'b0010, 1'b1);
        step_edge();

        // ---------------- ack on counter terminal ----------------
        settle(1'b0, 4'b0010, 1'b0);
        step_edge();
        settle(1'b0, 4'b0010, 1'b0);
        step_edge();
        for (int n = 1; n <= T; n++) begin
            settle(1'b0, 4'b0010, n == T);
            if (n == T) chk("ack at terminal: timeout", 32'(timeout), 32'h0);
            step_edge();
        end
        settle(1'b0, 4'b0010, 1'b0);
        chk("ack at terminal: released", 32'(grant), 32'h0);
        step_edge();

        // ---------------- ack together with req drop ----------------
        settle(1'b0, 4'b0001, 1'b0);
        step_edge();
        settle(1'b0, 4'b0001, 1'b0);
        step_edge();
        settle(1'b0, 4'b0000, 1'b1);
        chk("ack+drop grant", 32'(grant), 32'h1);
        chk("ack+drop timeout", 32'(timeout), 32'h0);
        step_edge();
        settle(1'b0, 4'b0011, 1'b0);
        chk("ack+drop turn", 32'(grant), 32'h0);
        step_edge();
        settle(1'b0, 4'b0011, 1'b0);
        step_edge();
        settle(1'b0, 4'b0011, 1'b0);
        chk("ack+drop ptr advanced", 32'(grant), 32'h2);
        step_edge();
        settle(1'b0, 4'b0011, 1'b1);
        step_edge();

        // ---------------- reset in the 3rd BUSY cycle of index 2 ----------------
        settle(1'b0, 4'b0100, 1'b0);
        step_edge();
        settle(1'b0, 4'b0100, 1'b0);
        step_edge();
        settle(1'b0, 4'b0100, 1'b0);
        chk("rst-mid busy1 grant", 32'(grant), 32'h4);
        step_edge();
        settle(1'b0, 4'b0100, 1'b0);
        step_edge();
        settle(1'b1, 4'b0100, 1'b0);
        chk("rst-mid busy3 grant", 32'(grant), 32'h4);
        step_edge();
        settle(1'b0, 4'b0101, 1'b0);
        chk("rst-mid grant dropped", 32'(grant), 32'h0);
        chk("rst-mid valid dropped", 32'(bus_valid), 32'h0);
        chk("rst-mid no timeout", 32'(timeout), 32'h0);
        step_edge();
        settle(1'b0, 4'b0101, 1'b0);
        chk("rst-mid ptr reset -> index 0", 32'(grant), 32'h1);
        step_edge();

        // ---------------- randomized traffic ----------------
        settle(1'b1, 4'b0000, 1'b0);
        step_edge();
        begin
            logic [3:0] q;
            q = 4'b0000;
            for (int c = 0; c < 3000; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 15) == 0) q[b] = ~q[b];
                end
                for (int b = 0; b < 4; b++) din[b] = $urandom;
                settle($urandom_range(0, 299) == 0, q, $urandom_range(0, 11) == 0);
                step_edge();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_arbiter_4
`default_nettype wire

// File: doc/bus_arbiter_4.md
BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, setting the maximum number of BUSY cycles before a grant is revoked without ack.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high means requester i wants the shared 32-bit bus.
REQ-005 The block SHALL have ports data_0, data_1, data_2 and data_3, input, 32 bits each: the requesters' bus payloads.
REQ-006 The block SHALL have port ack, input, 1 bit: the target accepted the current transfer.
REQ-007 The block SHALL have port grant, output, 4 bits: one-hot grant, registered.
REQ-008 The block SHALL have port sel, output, 2 bits: encoded index of the granted requester, registered; it drives the shared datapath mux select.
REQ-009 The block SHALL have port bus_valid, output, 1 bit: high exactly while a grant is held.
REQ-010 The block SHALL have port bus_data, output, 32 bits: the payload of the granted requester.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 The block SHALL implement the FSM states IDLE, BUSY and TURN.
REQ-013 In IDLE with req != 0, the block SHALL select the first set req bit searching ptr, ptr+1, ..., ptr+3 (mod 4), and at the next edge enter BUSY with grant, sel and bus_valid=1 set; request-to-grant latency is one cycle.
REQ-014 In IDLE with req == 0, the block SHALL remain in IDLE with grant=0 and bus_valid=0.
REQ-015 In BUSY, grant, sel and bus_valid SHALL remain stable, and bus_data SHALL equal data_<sel> combinationally.
REQ-016 When not in BUSY, bus_data SHALL be 32'h0.
REQ-017 In BUSY with ack=1, the block SHALL go to TURN at the next edge, clear grant and bus_valid, and set ptr to sel+1 mod 4 (3 wraps to 0).
REQ-018 In BUSY, if req[sel] drops before ack, the block SHALL abort to TURN with the same ptr update and no timeout pulse.
REQ-019 In BUSY, a cycle counter SHALL start at 0 on entry and increment each BUSY cycle without ack.
REQ-020 When the counter equals TIMEOUT-1 without ack, the block SHALL pulse timeout for one cycle, go to TURN and apply the same ptr update.
REQ-021 Simultaneous ack and req drop SHALL be treated as a normal completion.
REQ-022 Simultaneous ack and counter terminal SHALL be treated as completion, with timeout held at 0.
REQ-023 TURN SHALL last exactly one cycle and then go to IDLE, giving a minimum gap of 2 cycles between grants.
REQ-024 ack SHALL be ignored in IDLE and in TURN.
REQ-025 grant SHALL never have more than one bit set, and sel SHALL always equal the index of the set grant bit while bus_valid=1.
REQ-026 Changes to req bits other than req[sel] during BUSY SHALL have no effect until the next arbitration in IDLE.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, counter=0, grant=0, sel=0, bus_valid=0 and timeout=0, taking priority over all other inputs.
REQ-028 A reset asserted during BUSY SHALL drop grant and bus_valid at that edge with no timeout pulse, and ptr SHALL return to 0.

Structure
REQ-029 The state encoding (IDLE=2'b00, BUSY=2'b01, TURN=2'b10), requester count 4 and bus width 32 SHALL be defined as constants in the shared defines file.
REQ-030 The rotating-priority search SHALL be one combinational sub-module rr_pick (inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and any_req).
REQ-031 The payload selection SHALL reuse the team's 32-bit 4:1 mux, driven by sel.

Verification
REQ-032 The bench SHALL cover basic grant: after reset, req=4'b0100 and data_2=32'hDEADBEEF -> the next cycle has grant=4'b0100, sel=2, bus_valid=1 and bus_data=32'hDEADBEEF; ack one cycle later -> TURN, then IDLE.
REQ-033 The bench SHALL cover round-robin: req=4'b1111 held, with ack each grant -> grant order 0,1,2,3,0 and exactly 2 idle cycles between grants.
REQ-034 The bench SHALL cover wrap-around: last grant index 3, then req=4'b1001 -> the next grant is index 0, not 3.
REQ-035 The bench SHALL cover timeout: TIMEOUT=16, req=4'b0010 held, ack never asserted -> timeout=1 exactly in the 16th BUSY cycle, then TURN, and a re-grant of index 1 after IDLE.
REQ-036 The bench SHALL cover simultaneous events: ack on the same cycle as the counter terminal -> timeout stays 0; ack on the same cycle as req[sel] drops -> normal completion, ptr advanced.
REQ-037 The bench SHALL cover reset mid-operation: rst=1 in the 3rd BUSY cycle of index 2 -> the next cycle has grant=0, bus_valid=0 and ptr=0; with req=4'b0101 afterwards, index 0 is granted first.
